// File: rtl/idex_pkg.sv
// Shared ALU op codes and special register addresses for the ID/EX boundary.
package idex_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_AND   = 4'd1,
        OP_OR    = 4'd2,
        OP_SLL   = 4'd3,
        OP_SRL   = 4'd4,
        OP_SRA   = 4'd5,
        OP_SUB   = 4'd6,
        OP_EQUAL = 4'd7,
        OP_LESS  = 4'd8,
        OP_MOVE  = 4'd9,
        OP_EMPTY = 4'd15
    } alu_op_e;

    // A bubble presents the ALU with the no-operation code.
    localparam alu_op_e OP_BUBBLE = OP_EMPTY;

    localparam logic [3:0] REG_SP = 4'd8;
    localparam logic [3:0] REG_IH = 4'd9;
    localparam logic [3:0] REG_T  = 4'd10;
    localparam logic [3:0] REG_RA = 4'd11;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way priority operand select: EX/MEM result, then MEM/WB data, then latched value.
module fwd_mux #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [DATA_WIDTH-1:0]     src_data_i,
    input  logic                      mem_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    input  logic                      wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    always_comb begin
        data_o = src_data_i;
        if (mem_en_i && (mem_addr_i == src_addr_i)) begin
            data_o = mem_data_i;
        end else if (wb_en_i && (wb_addr_i == src_addr_i)) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall/bubble insertion.
// Define IDEX_STALL_CNT_EN to add a saturating stall_count output.
module id_ex_stage
    import idex_pkg::*;
#(
    parameter int OPERATOR_WIDTH = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [OPERATOR_WIDTH-1:0] id_op,
    input  logic [REG_ADDR_WIDTH-1:0] id_rx_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_ry_addr,
    input  logic [DATA_WIDTH-1:0]     id_rx_data,
    input  logic [DATA_WIDTH-1:0]     id_ry_data,
    input  logic                      id_rx_used,
    input  logic                      id_ry_used,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_use_imm,
    input  logic                      id_wb_en,
    input  logic                      id_mem_rd,
    input  logic                      id_mem_wr,
    input  logic [REG_ADDR_WIDTH-1:0] id_wb_addr,
    input  logic                      flush,
    input  logic                      mem_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_wb_addr,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic                      ex_wb_en,
    output logic                      ex_mem_rd,
    output logic                      ex_mem_wr,
    output logic [REG_ADDR_WIDTH-1:0] ex_wb_addr,
    output logic [OPERATOR_WIDTH-1:0] ex_op,
    output logic [DATA_WIDTH-1:0]     ex_srcdata_a,
    output logic [DATA_WIDTH-1:0]     ex_srcdata_b,
    output logic [DATA_WIDTH-1:0]     ex_store_data
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    localparam logic [OPERATOR_WIDTH-1:0] BUBBLE_OP = OPERATOR_WIDTH'(OP_BUBBLE);

    logic                      ex_valid_q, ex_valid_d;
    logic                      ex_wb_en_q, ex_wb_en_d;
    logic                      ex_mem_rd_q, ex_mem_rd_d;
    logic                      ex_mem_wr_q, ex_mem_wr_d;
    logic                      ex_use_imm_q, ex_use_imm_d;
    logic [REG_ADDR_WIDTH-1:0] ex_wb_addr_q, ex_wb_addr_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rx_addr_q, ex_rx_addr_d;
    logic [REG_ADDR_WIDTH-1:0] ex_ry_addr_q, ex_ry_addr_d;
    logic [OPERATOR_WIDTH-1:0] ex_op_q, ex_op_d;
    logic [DATA_WIDTH-1:0]     ex_rx_data_q, ex_rx_data_d;
    logic [DATA_WIDTH-1:0]     ex_ry_data_q, ex_ry_data_d;
    logic [DATA_WIDTH-1:0]     ex_imm_q, ex_imm_d;

    logic rx_hit, ry_hit, hazard, load_bubble;
    logic [DATA_WIDTH-1:0] fwd_rx, fwd_ry;

    // A store reads ry as its data even when the B operand is the immediate.
    assign rx_hit      = id_rx_used && (id_rx_addr == ex_wb_addr_q);
    assign ry_hit      = id_ry_used && (!id_use_imm || id_mem_wr) && (id_ry_addr == ex_wb_addr_q);
    assign hazard      = ex_valid_q && ex_mem_rd_q && id_valid && (rx_hit || ry_hit);
    assign id_stall    = hazard && !flush;
    assign load_bubble = flush || hazard || !id_valid;

    always_comb begin
        ex_valid_d   = 1'b0;
        ex_wb_en_d   = 1'b0;
        ex_mem_rd_d  = 1'b0;
        ex_mem_wr_d  = 1'b0;
        ex_use_imm_d = 1'b0;
        ex_wb_addr_d = '0;
        ex_rx_addr_d = '0;
        ex_ry_addr_d = '0;
        ex_op_d      = BUBBLE_OP;
        ex_rx_data_d = '0;
        ex_ry_data_d = '0;
        ex_imm_d     = '0;
        if (!load_bubble) begin
            ex_valid_d   = 1'b1;
            ex_wb_en_d   = id_wb_en;
            ex_mem_rd_d  = id_mem_rd;
            ex_mem_wr_d  = id_mem_wr;
            ex_use_imm_d = id_use_imm;
            ex_wb_addr_d = id_wb_addr;
            ex_rx_addr_d = id_rx_addr;
            ex_ry_addr_d = id_ry_addr;
            ex_op_d      = id_op;
            ex_imm_d     = id_imm;
            // Register file is written and read in the same cycle: take the write data.
            ex_rx_data_d = (wb_wb_en && (wb_wb_addr == id_rx_addr)) ? wb_data : id_rx_data;
            ex_ry_data_d = (wb_wb_en && (wb_wb_addr == id_ry_addr)) ? wb_data : id_ry_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_wb_en_q   <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_use_imm_q <= 1'b0;
            ex_wb_addr_q <= '0;
            ex_rx_addr_q <= '0;
            ex_ry_addr_q <= '0;
            ex_op_q      <= BUBBLE_OP;
            ex_rx_data_q <= '0;
            ex_ry_data_q <= '0;
            ex_imm_q     <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_wb_en_q   <= ex_wb_en_d;
            ex_mem_rd_q  <= ex_mem_rd_d;
            ex_mem_wr_q  <= ex_mem_wr_d;
            ex_use_imm_q <= ex_use_imm_d;
            ex_wb_addr_q <= ex_wb_addr_d;
            ex_rx_addr_q <= ex_rx_addr_d;
            ex_ry_addr_q <= ex_ry_addr_d;
            ex_op_q      <= ex_op_d;
            ex_rx_data_q <= ex_rx_data_d;
            ex_ry_data_q <= ex_ry_data_d;
            ex_imm_q     <= ex_imm_d;
        end
    end

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rx (
        .src_addr_i (ex_rx_addr_q),
        .src_data_i (ex_rx_data_q),
        .mem_en_i   (mem_wb_en),
        .mem_addr_i (mem_wb_addr),
        .mem_data_i (mem_result),
        .wb_en_i    (wb_wb_en),
        .wb_addr_i  (wb_wb_addr),
        .wb_data_i  (wb_data),
        .data_o     (fwd_rx)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_ry (
        .src_addr_i (ex_ry_addr_q),
        .src_data_i (ex_ry_data_q),
        .mem_en_i   (mem_wb_en),
        .mem_addr_i (mem_wb_addr),
        .mem_data_i (mem_result),
        .wb_en_i    (wb_wb_en),
        .wb_addr_i  (wb_wb_addr),
        .wb_data_i  (wb_data),
        .data_o     (fwd_ry)
    );

    assign ex_valid      = ex_valid_q;
    assign ex_wb_en      = ex_wb_en_q;
    assign ex_mem_rd     = ex_mem_rd_q;
    assign ex_mem_wr     = ex_mem_wr_q;
    assign ex_wb_addr    = ex_wb_addr_q;
    assign ex_op         = ex_op_q;
    assign ex_srcdata_a  = fwd_rx;
    assign ex_srcdata_b  = ex_use_imm_q ? ex_imm_q : fwd_ry;
    assign ex_store_data = fwd_ry;

`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (id_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
